controlador_partida: RTL and testbench

CONTROLADOR_PARTIDA -- requirements
Module: controlador_partida

---
 rtl/controlador_partida.sv | 272 +++++++++++++++++++++++++++
 tb/tb_controlador_partida.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/controlador_partida.sv
// rtl/controlador_partida.sv - battleship game controller: map preparation, shot resolution and game result
//
// Purpose:
//   Holds a ship map latched during preparation. Resolves confirmed shots during
//   attack, then reports victory or defeat. Every output is registered.
//
// Parameters:
//   LINHAS     board rows (default 7)
//   COLUNAS    board columns (default 5)
//   MAX_TIROS  shots per game, 1..LINHAS*COLUNAS (default 15)
//
// Ports:
//   clock            in   system clock, rising edge
//   reset            in   synchronous active-high reset
//   modo             in   2   00/11 off, 01 preparation, 10 attack
//   confirmar        in   1   debounced confirm level, edge-detected here
//   coord_linha      in   WL  target row
//   coord_coluna     in   WC  target column
//   mapa             in   N   candidate ship map, bit linha*COLUNAS+coluna
//   estado           out  2   00 DESLIGADO, 01 PREPARACAO, 10 ATAQUE, 11 FIM
//   tiros            out  N   cells already fired at
//   acertos          out  N   fired cells holding a ship
//   tiros_restantes  out  WT  shots left
//   acertos_cont     out  WN  hits so far
//   vitoria/derrota  out  1   game result, only meaningful in FIM
//   ev_acerto/ev_agua/ev_repetido/ev_invalido  out 1  one-cycle shot-result pulses
//
// Configuration macro:
//   TIRO_REPETIDO_CONSOME_EN  when defined, a repeated shot also consumes a shot
//                             and can end the game in defeat.

module controlador_partida #(
  parameter int LINHAS    = 7,
  parameter int COLUNAS   = 5,
  parameter int MAX_TIROS = 15,
  localparam int WL = $clog2(LINHAS),
  localparam int WC = $clog2(COLUNAS),
  localparam int N  = LINHAS * COLUNAS,
  localparam int WT = $clog2(MAX_TIROS + 1),
  localparam int WN = $clog2(N + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [1:0]    modo,
  input  logic          confirmar,
  input  logic [WL-1:0] coord_linha,
  input  logic [WC-1:0] coord_coluna,
  input  logic [N-1:0]  mapa,
  output logic [1:0]    estado,
  output logic [N-1:0]  tiros,
  output logic [N-1:0]  acertos,
  output logic [WT-1:0] tiros_restantes,
  output logic [WN-1:0] acertos_cont,
  output logic          vitoria,
  output logic          derrota,
  output logic          ev_acerto,
  output logic          ev_agua,
  output logic          ev_repetido,
  output logic          ev_invalido
);

  localparam int WI = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    DESLIGADO  = 2'b00,
    PREPARACAO = 2'b01,
    ATAQUE     = 2'b10,
    FIM        = 2'b11
  } estado_t;

  estado_t       state_q, state_d;
  logic [N-1:0]  mapa_q, mapa_d;
  logic          map_valid_q, map_valid_d;
  logic [WN-1:0] navios_q, navios_d;
  logic [N-1:0]  tiros_q, tiros_d;
  logic [N-1:0]  acertos_q, acertos_d;
  logic [WT-1:0] rest_q, rest_d;
  logic [WN-1:0] cont_q, cont_d;
  logic          vit_q, vit_d;
  logic          der_q, der_d;
  logic          ev_acerto_q, ev_acerto_d;
  logic          ev_agua_q, ev_agua_d;
  logic          ev_repetido_q, ev_repetido_d;
  logic          ev_invalido_q, ev_invalido_d;
  logic          conf_prev_q;

  logic          conf_edge;
  logic          modo_off;
  logic          coord_ok;
  logic [WI-1:0] idx;
  logic [WN-1:0] popcount;

  // Previous sample resets to 1 so a confirm level already high when reset
  // is released is not mistaken for a fresh press.
  assign conf_edge = confirmar && !conf_prev_q;
  assign modo_off  = (modo == 2'b00) || (modo == 2'b11);
  assign coord_ok  = (int'(coord_linha) < LINHAS) && (int'(coord_coluna) < COLUNAS);
  assign idx       = WI'(coord_linha) * WI'(COLUNAS) + WI'(coord_coluna);

  always_comb begin
    popcount = '0;
    for (int i = 0; i < N; i++) begin
      popcount = popcount + WN'(mapa[i]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= DESLIGADO;
      mapa_q        <= '0;
      map_valid_q   <= 1'b0;
      navios_q      <= '0;
      tiros_q       <= '0;
      acertos_q     <= '0;
      rest_q        <= '0;
      cont_q        <= '0;
      vit_q         <= 1'b0;
      der_q         <= 1'b0;
      ev_acerto_q   <= 1'b0;
      ev_agua_q     <= 1'b0;
      ev_repetido_q <= 1'b0;
      ev_invalido_q <= 1'b0;
      conf_prev_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      mapa_q        <= mapa_d;
      map_valid_q   <= map_valid_d;
      navios_q      <= navios_d;
      tiros_q       <= tiros_d;
      acertos_q     <= acertos_d;
      rest_q        <= rest_d;
      cont_q        <= cont_d;
      vit_q         <= vit_d;
      der_q         <= der_d;
      ev_acerto_q   <= ev_acerto_d;
      ev_agua_q     <= ev_agua_d;
      ev_repetido_q <= ev_repetido_d;
      ev_invalido_q <= ev_invalido_d;
      conf_prev_q   <= confirmar;
    end
  end

  // Confirm edges are only acted on in branches where no mode transition is
  // taken, so a simultaneous mode change always discards the edge.
  always_comb begin
    state_d       = state_q;
    mapa_d        = mapa_q;
    map_valid_d   = map_valid_q;
    navios_d      = navios_q;
    tiros_d       = tiros_q;
    acertos_d     = acertos_q;
    rest_d        = rest_q;
    cont_d        = cont_q;
    vit_d         = vit_q;
    der_d         = der_q;
    ev_acerto_d   = 1'b0;
    ev_agua_d     = 1'b0;
    ev_repetido_d = 1'b0;
    ev_invalido_d = 1'b0;

    if (modo_off) begin
      state_d     = DESLIGADO;
      mapa_d      = '0;
      map_valid_d = 1'b0;
      navios_d    = '0;
      tiros_d     = '0;
      acertos_d   = '0;
      rest_d      = '0;
      cont_d      = '0;
      vit_d       = 1'b0;
      der_d       = 1'b0;
    end else begin
      case (state_q)
        DESLIGADO: begin
          if (modo == 2'b01) begin
            state_d = PREPARACAO;
          end
        end

        PREPARACAO: begin
          if (modo == 2'b10 && map_valid_q) begin
            state_d   = ATAQUE;
            rest_d    = WT'(MAX_TIROS);
            tiros_d   = '0;
            acertos_d = '0;
            cont_d    = '0;
          end else if (conf_edge) begin
            // An empty map is rejected and any previously latched map stays.
            if (popcount == '0) begin
              ev_invalido_d = 1'b1;
            end else begin
              mapa_d      = mapa;
              navios_d    = popcount;
              map_valid_d = 1'b1;
            end
          end
        end

        ATAQUE: begin
          if (modo == 2'b01) begin
            state_d   = PREPARACAO;
            tiros_d   = '0;
            acertos_d = '0;
            rest_d    = '0;
            cont_d    = '0;
          end else if (conf_edge) begin
            if (!coord_ok) begin
              ev_invalido_d = 1'b1;
            end else if (tiros_q[idx]) begin
              ev_repetido_d = 1'b1;
`ifdef TIRO_REPETIDO_CONSOME_EN
              rest_d = rest_q - WT'(1);
              if (rest_d == '0) begin
                state_d = FIM;
                der_d   = 1'b1;
              end
`endif
            end else begin
              tiros_d[idx] = 1'b1;
              rest_d       = rest_q - WT'(1);
              if (mapa_q[idx]) begin
                acertos_d[idx] = 1'b1;
                cont_d         = cont_q + WN'(1);
                ev_acerto_d    = 1'b1;
              end else begin
                ev_agua_d = 1'b1;
              end
              // Victory is checked first so sinking the last ship with the
              // last shot counts as a win.
              if (cont_d == navios_q) begin
                state_d = FIM;
                vit_d   = 1'b1;
              end else if (rest_d == '0) begin
                state_d = FIM;
                der_d   = 1'b1;
              end
            end
          end
        end

        FIM: begin
          if (modo == 2'b01) begin
            state_d   = PREPARACAO;
            tiros_d   = '0;
            acertos_d = '0;
            rest_d    = '0;
            cont_d    = '0;
            vit_d     = 1'b0;
            der_d     = 1'b0;
          end
        end

        default: begin
          state_d = DESLIGADO;
        end
      endcase
    end
  end

  assign estado          = state_q;
  assign tiros           = tiros_q;
  assign acertos         = acertos_q;
  assign tiros_restantes = rest_q;
  assign acertos_cont    = cont_q;
  assign vitoria         = vit_q;
  assign derrota         = der_q;
  assign ev_acerto       = ev_acerto_q;
  assign ev_agua         = ev_agua_q;
  assign ev_repetido     = ev_repetido_q;
  assign ev_invalido     = ev_invalido_q;

endmodule

// File: tb/tb_controlador_partida.sv
// tb/tb_controlador_partida.sv - directed self-checking bench for controlador_partida

module tb_controlador_partida;

  localparam int LINHAS    = 7;
  localparam int COLUNAS   = 5;
  localparam int MAX_TIROS = 15;
  localparam int WL = $clog2(LINHAS);
  localparam int WC = $clog2(COLUNAS);
  localparam int N  = LINHAS * COLUNAS;
  localparam int WT = $clog2(MAX_TIROS + 1);
  localparam int WN = $clog2(N + 1);

  logic          clock = 1'b0;
  logic          reset;
  logic [1:0]    modo;
  logic          confirmar;
  logic [WL-1:0] coord_linha;
  logic [WC-1:0] coord_coluna;
  logic [N-1:0]  mapa;
  logic [1:0]    estado;
  logic [N-1:0]  tiros;
  logic [N-1:0]  acertos;
  logic [WT-1:0] tiros_restantes;
  logic [WN-1:0] acertos_cont;
  logic          vitoria;
  logic          derrota;
  logic          ev_acerto;
  logic          ev_agua;
  logic          ev_repetido;
  logic          ev_invalido;

  int checks = 0;
  int errors = 0;

`ifdef TIRO_REPETIDO_CONSOME_EN
  localparam int REP_COST = 1;
`else
  localparam int REP_COST = 0;
`endif

  controlador_partida #(
    .LINHAS(LINHAS), .COLUNAS(COLUNAS), .MAX_TIROS(MAX_TIROS)
  ) dut (
    .clock(clock), .reset(reset), .modo(modo), .confirmar(confirmar),
    .coord_linha(coord_linha), .coord_coluna(coord_coluna), .mapa(mapa),
    .estado(estado), .tiros(tiros), .acertos(acertos),
    .tiros_restantes(tiros_restantes), .acertos_cont(acertos_cont),
    .vitoria(vitoria), .derrota(derrota),
    .ev_acerto(ev_acerto), .ev_agua(ev_agua),
    .ev_repetido(ev_repetido), .ev_invalido(ev_invalido)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [3:0] evs();
    return {ev_acerto, ev_agua, ev_repetido, ev_invalido};
  endfunction

  task automatic fire(input int l, input int c, output logic [3:0] ev);
    coord_linha  = WL'(l);
    coord_coluna = WC'(c);
    confirmar    = 1'b1;
    tick();
    ev = evs();
    confirmar = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; modo = 2'b00; confirmar = 1'b0;
    coord_linha = '0; coord_coluna = '0; mapa = '0;
    tick(); tick();
    checks++;
    if (estado !== 2'b00 || tiros !== '0 || acertos !== '0 || tiros_restantes !== '0 ||
        acertos_cont !== '0 || vitoria !== 1'b0 || derrota !== 1'b0 || evs() !== 4'b0) begin
      errors++;
      $display("FAIL reset_state estado=%b tiros=%h rest=%0d cont=%0d v=%b d=%b ev=%b expected all zero",
               estado, tiros, tiros_restantes, acertos_cont, vitoria, derrota, evs());
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_mapa_vazio();
    logic [3:0] ev;
    modo = 2'b01; tick();
    checks++;
    if (estado !== 2'b01) begin errors++; $display("FAIL enter_prep estado=%b expected 01", estado); end
    mapa = '0;
    fire(0, 0, ev);
    checks++;
    if (ev !== 4'b0001) begin errors++; $display("FAIL empty_map_ev ev=%b expected 0001", ev); end
    modo = 2'b10; tick(); tick();
    checks++;
    if (estado !== 2'b01) begin errors++; $display("FAIL attack_without_map estado=%b expected 01", estado); end
  endtask

  task automatic test_vitoria();
    logic [3:0] ev;
    modo = 2'b01; tick();
    mapa = 35'h3;
    fire(4, 4, ev);
    checks++;
    if (ev !== 4'b0000) begin errors++; $display("FAIL latch_map_ev ev=%b expected 0000", ev); end
    modo = 2'b10; tick();
    checks++;
    if (estado !== 2'b10 || tiros_restantes !== 4'd15) begin
      errors++; $display("FAIL enter_attack estado=%b rest=%0d expected 10/15", estado, tiros_restantes);
    end
    fire(0, 0, ev);
    checks++;
    if (ev !== 4'b1000 || acertos_cont !== 6'd1 || tiros_restantes !== 4'd14 || acertos !== 35'h1) begin
      errors++; $display("FAIL hit_00 ev=%b cont=%0d rest=%0d acertos=%h expected 1000/1/14/1",
                         ev, acertos_cont, tiros_restantes, acertos);
    end
    fire(0, 1, ev);
    checks++;
    if (estado !== 2'b11 || vitoria !== 1'b1 || derrota !== 1'b0 || acertos_cont !== 6'd2 ||
        tiros_restantes !== 4'd13 || ev !== 4'b1000) begin
      errors++; $display("FAIL victory estado=%b v=%b d=%b cont=%0d rest=%0d ev=%b expected 11/1/0/2/13/1000",
                         estado, vitoria, derrota, acertos_cont, tiros_restantes, ev);
    end
    fire(1, 1, ev);
    checks++;
    if (ev !== 4'b0000 || tiros !== 35'h3 || estado !== 2'b11) begin
      errors++; $display("FAIL fim_ignores ev=%b tiros=%h estado=%b expected 0000/3/11", ev, tiros, estado);
    end
  endtask

  task automatic test_derrota();
    logic [3:0] ev;
    int bad;
    modo = 2'b01; tick();
    checks++;
    if (estado !== 2'b01 || vitoria !== 1'b0 || tiros !== '0) begin
      errors++; $display("FAIL fim_to_prep estado=%b v=%b tiros=%h expected 01/0/0", estado, vitoria, tiros);
    end
    modo = 2'b10; tick();
    bad = 0;
    for (int k = 2; k < 17; k++) begin
      fire(k / COLUNAS, k % COLUNAS, ev);
      if (ev !== 4'b0100) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL water_events bad=%0d expected 0", bad); end
    checks++;
    if (estado !== 2'b11 || derrota !== 1'b1 || vitoria !== 1'b0 || tiros_restantes !== '0 ||
        acertos_cont !== '0 || tiros !== 35'h1FFFC) begin
      errors++; $display("FAIL defeat estado=%b d=%b v=%b rest=%0d cont=%0d tiros=%h expected 11/1/0/0/0/1fffc",
                         estado, derrota, vitoria, tiros_restantes, acertos_cont, tiros);
    end
  endtask

  task automatic test_repetido();
    logic [3:0] ev;
    modo = 2'b01; tick();
    modo = 2'b10; tick();
    fire(2, 3, ev);
    checks++;
    if (ev !== 4'b0100 || tiros_restantes !== 4'd14) begin
      errors++; $display("FAIL first_23 ev=%b rest=%0d expected 0100/14", ev, tiros_restantes);
    end
    fire(2, 3, ev);
    checks++;
    if (ev !== 4'b0010 || tiros_restantes !== WT'(14 - REP_COST) || tiros !== 35'h2000) begin
      errors++; $display("FAIL repeat_23 ev=%b rest=%0d tiros=%h expected 0010/%0d/2000",
                         ev, tiros_restantes, tiros, 14 - REP_COST);
    end
  endtask

  task automatic test_invalido();
    logic [3:0] ev;
    int pulses;
    fire(7, 0, ev);
    checks++;
    if (ev !== 4'b0001 || tiros !== 35'h2000) begin
      errors++; $display("FAIL invalid_row ev=%b tiros=%h expected 0001/2000", ev, tiros);
    end
    fire(0, 5, ev);
    checks++;
    if (ev !== 4'b0001 || tiros !== 35'h2000 || tiros_restantes !== WT'(14 - REP_COST)) begin
      errors++; $display("FAIL invalid_col ev=%b tiros=%h rest=%0d expected 0001/2000/%0d",
                         ev, tiros, tiros_restantes, 14 - REP_COST);
    end
    coord_linha = 3'd3; coord_coluna = 3'd0; confirmar = 1'b1;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (ev_agua === 1'b1) pulses++;
    end
    confirmar = 1'b0; tick();
    checks++;
    if (pulses != 1 || tiros !== 35'hA000 || tiros_restantes !== WT'(13 - REP_COST)) begin
      errors++; $display("FAIL held_confirm pulses=%0d tiros=%h rest=%0d expected 1/a000/%0d",
                         pulses, tiros, tiros_restantes, 13 - REP_COST);
    end
  endtask

  task automatic test_mesmo_ciclo();
    coord_linha = 3'd4; coord_coluna = 3'd4;
    modo = 2'b01; confirmar = 1'b1;
    tick();
    checks++;
    if (estado !== 2'b01 || evs() !== 4'b0000 || tiros !== '0) begin
      errors++; $display("FAIL mode_and_edge estado=%b ev=%b tiros=%h expected 01/0000/0", estado, evs(), tiros);
    end
    confirmar = 1'b0; tick();
  endtask

  task automatic test_reset_meio();
    logic [3:0] ev;
    modo = 2'b10; tick();
    fire(0, 0, ev);
    fire(1, 0, ev);
    fire(1, 1, ev);
    checks++;
    if (estado !== 2'b10 || acertos_cont !== 6'd1 || tiros_restantes !== 4'd12) begin
      errors++; $display("FAIL pre_reset estado=%b cont=%0d rest=%0d expected 10/1/12", estado, acertos_cont, tiros_restantes);
    end
    reset = 1'b1; tick();
    checks++;
    if (estado !== 2'b00 || tiros !== '0 || acertos !== '0 || tiros_restantes !== '0 ||
        acertos_cont !== '0 || vitoria !== 1'b0 || derrota !== 1'b0 || evs() !== 4'b0) begin
      errors++; $display("FAIL mid_game_reset estado=%b tiros=%h rest=%0d cont=%0d expected all zero",
                         estado, tiros, tiros_restantes, acertos_cont);
    end
    reset = 1'b0;
    modo = 2'b01; tick();
    modo = 2'b10; tick(); tick();
    checks++;
    if (estado !== 2'b01) begin errors++; $display("FAIL map_cleared_by_reset estado=%b expected 01", estado); end
  endtask

  initial begin
    test_reset();
    test_mapa_vazio();
    test_vitoria();
    test_derrota();
    test_repetido();
    test_invalido();
    test_mesmo_ciclo();
    test_reset_meio();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
